// File: rtl/md5_core_dispatch_pkg.sv
// Shared types and widths for the MD5 core dispatcher.
package md5_core_dispatch_pkg;

    localparam int unsigned MSG_W_DEF  = 128;
    localparam int unsigned DIG_W_DEF  = 128;
    localparam int unsigned CORE_IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FOUND = 2'd2
    } state_e;

endpackage

// File: rtl/md5_core_dispatch_if.sv
// Candidate stream and per-core MD5 bus between generator, dispatcher and cores.
interface md5_core_dispatch_if #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned MSG_W     = 128,
    parameter int unsigned DIG_W     = 128
);
    logic                       cand_valid;
    logic                       cand_ready;
    logic [MSG_W-1:0]           cand_data;
    logic [7:0]                 cand_width;
    logic [NUM_CORES*MSG_W-1:0] core_msg;
    logic [NUM_CORES*8-1:0]     core_width;
    logic [NUM_CORES-1:0]       core_valid;
    logic [NUM_CORES-1:0]       core_ready;
    logic [NUM_CORES*DIG_W-1:0] core_dig;
    logic [NUM_CORES-1:0]       core_dval;

    modport master (
        output cand_valid, cand_data, cand_width, core_ready, core_dig, core_dval,
        input  cand_ready, core_msg, core_width, core_valid
    );

    modport slave (
        input  cand_valid, cand_data, cand_width, core_ready, core_dig, core_dval,
        output cand_ready, core_msg, core_width, core_valid
    );
endinterface

// File: rtl/md5_core_dispatch_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
module md5_core_dispatch_rr_arbiter
    import md5_core_dispatch_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]          req,
    input  logic [CORE_IDX_W-1:0] ptr,
    output logic [N-1:0]          gnt_c,
    output logic [CORE_IDX_W-1:0] idx_c,
    output logic                  any_c
);

    int unsigned slot;

    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        slot  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            slot = (32'(ptr) + k) % N;
            if (!any_c && ((req & (N'(1) << slot)) != '0)) begin
                any_c = 1'b1;
                gnt_c = N'(1) << slot;
                idx_c = CORE_IDX_W'(slot);
            end
        end
    end

endmodule

// File: rtl/md5_core_dispatch.sv
// Spreads candidates over NUM_CORES MD5 cores, checks each digest against the
// target and latches the first matching cleartext.
module md5_core_dispatch
    import md5_core_dispatch_pkg::*;
#(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned MSG_W     = MSG_W_DEF,
    parameter int unsigned DIG_W     = DIG_W_DEF,
    parameter int unsigned CNT_W     = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic [DIG_W-1:0]      target,
    md5_core_dispatch_if.slave    bus,
    output logic                  found,
    output logic [MSG_W-1:0]      found_msg,
    output logic [CORE_IDX_W-1:0] found_core,
    output logic [CNT_W-1:0]      tested,
    output logic                  busy,
    output logic                  proto_err
);

    state_e                     state_q, state_d;
    logic [DIG_W-1:0]           target_q, target_d;
    logic [NUM_CORES-1:0]       inflight_q, inflight_d;
    logic [NUM_CORES-1:0]       core_valid_q, core_valid_d;
    logic [CORE_IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES*MSG_W-1:0] core_msg_q, core_msg_d;
    logic [NUM_CORES*8-1:0]     core_width_q, core_width_d;
    logic [MSG_W-1:0]           shadow_q [NUM_CORES];
    logic [MSG_W-1:0]           shadow_d [NUM_CORES];
    logic                       found_q, found_d;
    logic [MSG_W-1:0]           found_msg_q, found_msg_d;
    logic [CORE_IDX_W-1:0]      found_core_q, found_core_d;
    logic [CNT_W-1:0]           tested_q, tested_d;
    logic                       busy_q, busy_d;
    logic                       proto_err_q, proto_err_d;

    logic [NUM_CORES-1:0]       free_c, gnt_c;
    logic [CORE_IDX_W-1:0]      gnt_idx_c, hit_idx_c;
    logic                       gnt_any_c, run_c, accept_c, hit_c;
    logic [MSG_W-1:0]           hit_msg_c;

    // A core retiring this cycle still counts as busy, so it is re-granted next cycle at earliest.
    assign free_c   = bus.core_ready & ~inflight_q;
    assign run_c    = (state_q == ST_RUN);
    assign accept_c = run_c & gnt_any_c & bus.cand_valid;

    md5_core_dispatch_rr_arbiter #(.N(NUM_CORES)) u_arb (
        .req   (free_c),
        .ptr   (rr_ptr_q),
        .gnt_c (gnt_c),
        .idx_c (gnt_idx_c),
        .any_c (gnt_any_c)
    );

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        inflight_d   = inflight_q;
        core_valid_d = '0;
        rr_ptr_d     = rr_ptr_q;
        core_msg_d   = core_msg_q;
        core_width_d = core_width_q;
        shadow_d     = shadow_q;
        found_d      = found_q;
        found_msg_d  = found_msg_q;
        found_core_d = found_core_q;
        tested_d     = tested_q;
        proto_err_d  = proto_err_q;
        hit_c        = 1'b0;
        hit_idx_c    = '0;
        hit_msg_c    = '0;

        // Retire results; ascending scan makes the lowest matching core win.
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (bus.core_dval[i]) begin
                if (inflight_q[i]) begin
                    inflight_d[i] = 1'b0;
                    if (state_q != ST_IDLE) tested_d = tested_d + CNT_W'(1);
                    if (run_c && !hit_c && (bus.core_dig[i*DIG_W +: DIG_W] == target_q)) begin
                        hit_c     = 1'b1;
                        hit_idx_c = CORE_IDX_W'(i);
                        hit_msg_c = shadow_q[i];
                    end
                end else begin
                    proto_err_d = 1'b1;
                end
            end
        end

        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (accept_c && gnt_c[i]) begin
                inflight_d[i]                  = 1'b1;
                core_valid_d[i]                = 1'b1;
                core_msg_d[i*MSG_W +: MSG_W]   = bus.cand_data;
                core_width_d[i*8 +: 8]         = bus.cand_width;
                shadow_d[i]                    = bus.cand_data;
            end
        end
        if (accept_c) begin
            rr_ptr_d = (gnt_idx_c == CORE_IDX_W'(NUM_CORES - 1)) ? '0 : gnt_idx_c + CORE_IDX_W'(1);
        end

        if (clear) begin
            state_d      = ST_IDLE;
            found_d      = 1'b0;
            found_msg_d  = '0;
            found_core_d = '0;
            tested_d     = '0;
            proto_err_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d  = ST_RUN;
                        target_d = target;
                    end
                end
                ST_RUN: begin
                    if (hit_c) begin
                        state_d      = ST_FOUND;
                        found_d      = 1'b1;
                        found_msg_d  = hit_msg_c;
                        found_core_d = hit_idx_c;
                    end
                end
                ST_FOUND: ;
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = |inflight_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            inflight_q   <= '0;
            core_valid_q <= '0;
            rr_ptr_q     <= '0;
            core_msg_q   <= '0;
            core_width_q <= '0;
            shadow_q     <= '{default: '0};
            found_q      <= 1'b0;
            found_msg_q  <= '0;
            found_core_q <= '0;
            tested_q     <= '0;
            busy_q       <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            inflight_q   <= inflight_d;
            core_valid_q <= core_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            core_msg_q   <= core_msg_d;
            core_width_q <= core_width_d;
            shadow_q     <= shadow_d;
            found_q      <= found_d;
            found_msg_q  <= found_msg_d;
            found_core_q <= found_core_d;
            tested_q     <= tested_d;
            busy_q       <= busy_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign bus.cand_ready = run_c & gnt_any_c;
    assign bus.core_msg   = core_msg_q;
    assign bus.core_width = core_width_q;
    assign bus.core_valid = core_valid_q;
    assign found          = found_q;
    assign found_msg      = found_msg_q;
    assign found_core     = found_core_q;
    assign tested         = tested_q;
    assign busy           = busy_q;
    assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_md5_core_dispatch.sv
// Bench for md5_core_dispatch: directed stimulus, cycle-level reference model,
// and a narrow-counter twin instance that exposes tested-counter wrap.
module tb_md5_core_dispatch;

    localparam int unsigned N  = 2;
    localparam int unsigned MW = 128;
    localparam int unsigned DW = 128;

    localparam logic [DW-1:0] T  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [DW-1:0] DX = 128'h1111;
    localparam logic [DW-1:0] DY = 128'h2222;

    logic          clk = 1'b0;
    logic          reset = 1'b0, start = 1'b0, clear = 1'b0;
    logic [DW-1:0] target = '0;

    always #5 clk = ~clk;

    md5_core_dispatch_if #(.NUM_CORES(N), .MSG_W(MW), .DIG_W(DW)) bus_a ();
    md5_core_dispatch_if #(.NUM_CORES(N), .MSG_W(MW), .DIG_W(DW)) bus_b ();

    assign bus_b.cand_valid = bus_a.cand_valid;
    assign bus_b.cand_data  = bus_a.cand_data;
    assign bus_b.cand_width = bus_a.cand_width;
    assign bus_b.core_ready = bus_a.core_ready;
    assign bus_b.core_dig   = bus_a.core_dig;
    assign bus_b.core_dval  = bus_a.core_dval;

    logic          found_a, busy_a, perr_a, found_b, busy_b, perr_b;
    logic [MW-1:0] fmsg_a, fmsg_b;
    logic [2:0]    fcore_a, fcore_b;
    logic [47:0]   tested_a;
    logic [1:0]    tested_b;

    md5_core_dispatch #(.NUM_CORES(N), .MSG_W(MW), .DIG_W(DW), .CNT_W(48)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear), .target(target), .bus(bus_a),
        .found(found_a), .found_msg(fmsg_a), .found_core(fcore_a), .tested(tested_a),
        .busy(busy_a), .proto_err(perr_a)
    );

    md5_core_dispatch #(.NUM_CORES(N), .MSG_W(MW), .DIG_W(DW), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .clear(clear), .target(target), .bus(bus_b),
        .found(found_b), .found_msg(fmsg_b), .found_core(fcore_b), .tested(tested_b),
        .busy(busy_b), .proto_err(perr_b)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the dispatcher must be holding after each clock edge.
    bit                 m_run = 1'b0, m_found = 1'b0, m_perr = 1'b0;
    bit [N-1:0]         m_inf = '0, m_vpulse = '0;
    logic [MW-1:0]      m_shadow [N];
    logic [N*MW-1:0]    m_msg = '0;
    logic [N*8-1:0]     m_width = '0;
    int                 m_ptr = 0, m_fcore = 0;
    longint unsigned    m_tested = 0;
    logic [MW-1:0]      m_fmsg = '0;
    logic [DW-1:0]      m_target = '0;

    function automatic bit exp_ready();
        return m_run && ((bus_a.core_ready & ~m_inf) != '0);
    endfunction

    always @(posedge clk) begin
        int g, hit, j;
        logic [MW-1:0] hmsg;
        if (!reset) begin
            m_run = 0; m_found = 0; m_perr = 0; m_inf = '0; m_vpulse = '0;
            m_msg = '0; m_width = '0; m_ptr = 0; m_fcore = 0; m_tested = 0;
            m_fmsg = '0; m_target = '0;
            for (int i = 0; i < N; i++) m_shadow[i] = '0;
        end else begin
            g = -1; hit = -1; hmsg = '0;
            if (exp_ready() && bus_a.cand_valid) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (g < 0 && bus_a.core_ready[j] && !m_inf[j]) g = j;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (bus_a.core_dval[i]) begin
                    if (m_inf[i]) begin
                        m_inf[i] = 1'b0;
                        if (m_run || m_found) m_tested = m_tested + 1;
                        if (m_run && hit < 0 && bus_a.core_dig[i*DW +: DW] == m_target) begin
                            hit = i; hmsg = m_shadow[i];
                        end
                    end else m_perr = 1'b1;
                end
            end
            m_vpulse = '0;
            if (g >= 0) begin
                m_inf[g] = 1'b1;
                m_vpulse[g] = 1'b1;
                m_shadow[g] = bus_a.cand_data;
                m_msg[g*MW +: MW] = bus_a.cand_data;
                m_width[g*8 +: 8] = bus_a.cand_width;
                m_ptr = (g + 1) % N;
            end
            if (clear) begin
                m_run = 0; m_found = 0; m_fmsg = '0; m_fcore = 0; m_tested = 0; m_perr = 0;
            end else if (!m_run && !m_found) begin
                if (start) begin m_run = 1; m_target = target; end
            end else if (m_run && hit >= 0) begin
                m_run = 0; m_found = 1; m_fmsg = hmsg; m_fcore = hit;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cand_ready", bus_a.cand_ready, exp_ready());
            chk("core_valid", bus_a.core_valid, m_vpulse);
            chk("core_msg", bus_a.core_msg, m_msg);
            chk("core_width", bus_a.core_width, m_width);
            chk("found", found_a, m_found);
            chk("found_msg", fmsg_a, m_fmsg);
            chk("found_core", fcore_a, 3'(m_fcore));
            chk("tested", tested_a, 48'(m_tested));
            chk("busy", busy_a, |m_inf);
            chk("proto_err", perr_a, m_perr);
            chk("b_tested", tested_b, 2'(m_tested));
            chk("b_found", found_b, m_found);
            chk("b_core_valid", bus_b.core_valid, m_vpulse);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cand(input bit v, input logic [MW-1:0] d, input logic [7:0] w);
        bus_a.cand_valid = v;
        bus_a.cand_data  = d;
        bus_a.cand_width = w;
    endtask

    task automatic set_dval(input logic [N-1:0] m, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bus_a.core_dval = m;
        bus_a.core_dig  = {d1, d0};
    endtask

    initial begin
        set_cand(0, '0, 8'd0);
        set_dval('0, '0, '0);
        bus_a.core_ready = 2'b11;
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_found", found_a, 0);
        chk("rst_tested", tested_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ready", bus_a.cand_ready, 0);

        reset = 1'b1; target = T; start = 1'b1; tick(); start = 1'b0;
        chk("run_ready", bus_a.cand_ready, 1);

        // four candidates: core0, core1, wait, core0, core1
        set_cand(1, 128'hC0, 8'd64); tick();
        chk("d0_valid", bus_a.core_valid, 2'b01);
        chk("d0_msg", bus_a.core_msg[127:0], 128'hC0);
        chk("d0_width", bus_a.core_width[7:0], 8'd64);
        set_cand(1, 128'hC1, 8'd72); tick();
        chk("d1_valid", bus_a.core_valid, 2'b10);
        chk("full_ready", bus_a.cand_ready, 0);
        set_cand(1, 128'hC2, 8'd80); set_dval(2'b01, DX, '0); tick();
        chk("wait_valid", bus_a.core_valid, 2'b00);
        chk("ret0_tested", tested_a, 1);
        set_dval('0, '0, '0); tick();
        chk("d2_valid", bus_a.core_valid, 2'b01);
        chk("d2_msg", bus_a.core_msg[127:0], 128'hC2);
        set_cand(1, 128'hC3, 8'd88); set_dval(2'b10, '0, DY); tick();
        chk("ret1_tested", tested_a, 2);
        set_dval('0, '0, '0); tick();
        chk("d3_valid", bus_a.core_valid, 2'b10);
        chk("d3_msg", bus_a.core_msg[255:128], 128'hC3);

        // core1 matches on its second message
        set_cand(0, '0, 8'd0); set_dval(2'b10, '0, T); tick();
        chk("m_found", found_a, 1);
        chk("m_found_msg", fmsg_a, 128'hC3);
        chk("m_found_core", fcore_a, 1);
        chk("m_tested", tested_a, 3);
        chk("m_busy", busy_a, 1);
        set_dval('0, '0, '0); set_cand(1, 128'hC4, 8'd8); tick();
        chk("f_ready", bus_a.cand_ready, 0);
        chk("f_valid", bus_a.core_valid, 2'b00);
        set_cand(0, '0, 8'd0); set_dval(2'b01, T, '0); tick();
        chk("f_tested", tested_a, 4);
        chk("f_core_frozen", fcore_a, 1);
        chk("f_busy", busy_a, 0);
        set_dval('0, '0, '0); clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_found", found_a, 0);
        chk("clr_tested", tested_a, 0);

        // simultaneous matches: lowest core wins
        start = 1'b1; tick(); start = 1'b0;
        set_cand(1, 128'hC5, 8'd16); tick();
        set_cand(1, 128'hC6, 8'd24); tick();
        set_cand(0, '0, 8'd0); set_dval(2'b11, T, T); tick();
        chk("sim_found_core", fcore_a, 0);
        chk("sim_found_msg", fmsg_a, 128'hC5);
        chk("sim_tested", tested_a, 2);
        chk("model_tested", m_tested, 2);

        // result from a core with nothing in flight
        set_dval(2'b01, DX, '0); tick();
        chk("perr_set", perr_a, 1);
        chk("perr_tested", tested_a, 2);
        set_dval('0, '0, '0); tick();
        chk("perr_sticky", perr_a, 1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("perr_clr", perr_a, 0);

        // narrow twin counter wraps while the wide one keeps counting
        start = 1'b1; tick(); start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            set_cand(1, 128'hC7 + MW'(r), 8'd32); tick();
            set_cand(1, 128'hC8 + MW'(r), 8'd40); tick();
            set_cand(0, '0, 8'd0); set_dval(2'b11, DX, DY); tick();
            set_dval('0, '0, '0);
        end
        chk("wrap_a", tested_a, 4);
        chk("wrap_b", tested_b, 0);
        chk("wrap_found_b", found_b, 0);

        // reset with two cores in flight
        set_cand(1, 128'hC9, 8'd48); tick();
        set_cand(1, 128'hCA, 8'd56); tick();
        set_cand(0, '0, 8'd0);
        chk("pre_rst_busy", busy_a, 1);
        reset = 1'b0; tick();
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_tested", tested_a, 0);
        chk("mid_rst_msg", bus_a.core_msg, '0);
        chk("mid_rst_ready", bus_a.cand_ready, 0);
        reset = 1'b1; tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
